// File: rtl/lsu_pkg.sv
// lsu_pkg: request opcode and FSM state encodings shared by the LSU and its lane logic.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_load(lsu_op_e op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic misaligned(lsu_op_e op, logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

    // Clears the address bits an access of this size cannot legally carry.
    function automatic logic [31:0] align_addr(lsu_op_e op, logic [31:0] a);
        case (op)
            OP_LW, OP_SW:         return {a[31:2], 2'b00};
            OP_LH, OP_LHU, OP_SH: return {a[31:1], 1'b0};
            default:              return a;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: load lane select with sign/zero extension and sub-word store merge (combinational).
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_ext;
    logic signed [31:0] half_ext;
    logic [31:0]        byte_mrg;
    logic [31:0]        half_mrg;

    always_comb begin
        byte_s   = '0;
        byte_mrg = rdata;
        case (byte_sel)
            2'd0: begin
                byte_s   = rdata[7:0];
                byte_mrg = {rdata[31:8], wdata[7:0]};
            end
            2'd1: begin
                byte_s   = rdata[15:8];
                byte_mrg = {rdata[31:16], wdata[7:0], rdata[7:0]};
            end
            2'd2: begin
                byte_s   = rdata[23:16];
                byte_mrg = {rdata[31:24], wdata[7:0], rdata[15:0]};
            end
            default: begin
                byte_s   = rdata[31:24];
                byte_mrg = {wdata[7:0], rdata[23:0]};
            end
        endcase

        if (byte_sel[1]) begin
            half_s   = rdata[31:16];
            half_mrg = {wdata[15:0], rdata[15:0]};
        end else begin
            half_s   = rdata[15:0];
            half_mrg = {rdata[31:16], wdata[15:0]};
        end

        byte_ext = 32'(byte_s);
        half_ext = 32'(half_s);

        case (op)
            OP_LB:   load_data = byte_ext;
            OP_LBU:  load_data = {24'd0, byte_s};
            OP_LH:   load_data = half_ext;
            OP_LHU:  load_data = {16'd0, half_s};
            default: load_data = rdata;
        endcase

        case (op)
            OP_SB:   merged = byte_mrg;
            OP_SH:   merged = half_mrg;
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit; SB/SH are done as read-modify-write of the word.
// Define LSU_MISALIGN_CHECK_EN to report misaligned LW/SW/LH/LHU/SH via rsp_err instead of aligning.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata
);

    // Word-aligned byte mask that wraps addresses onto the memory's word index.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_WORDS * 4 - 4);

    lsu_state_e  state, state_nxt;
    lsu_op_e     req_op_e, op_p0;
    logic [31:0] addr_p0, wdata_p0, pc_p0, rdata_p0;
    logic [31:0] load_data, merged;
    logic        accept;

    assign req_op_e  = lsu_op_e'(req_op);
    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_p0;
    assign mem_we    = (state == S_WR);
    assign mem_addr  = addr_p0 & ADDR_MASK;
    assign mem_wdata = wdata_p0;
    assign mem_pc    = pc_p0;

`ifdef LSU_MISALIGN_CHECK_EN
    logic req_mis, err_p0;
    assign req_mis = misaligned(req_op_e, req_addr[1:0]);
    assign rsp_err = err_p0;
`else
    assign rsp_err = 1'b0;
`endif

    lsu_lane u_lane (
        .op        (op_p0),
        .byte_sel  (addr_p0[1:0]),
        .rdata     (mem_rdata),
        .wdata     (wdata_p0),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op_e == OP_SW) state_nxt = S_WR;
                    else                   state_nxt = S_RD;
`ifdef LSU_MISALIGN_CHECK_EN
                    if (req_mis) state_nxt = S_RESP;
`endif
                end
            end
            S_RD:    state_nxt = is_load(op_p0) ? S_RESP : S_WR;
            S_WR:    state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // p0: request fields captured at accept; RD folds the sampled word into them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_p0    <= OP_LW;
            addr_p0  <= '0;
            wdata_p0 <= '0;
            pc_p0    <= '0;
            rdata_p0 <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_p0   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_p0    <= req_op_e;
                addr_p0  <= align_addr(req_op_e, req_addr);
                wdata_p0 <= req_wdata;
                pc_p0    <= req_pc;
                rdata_p0 <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                err_p0   <= req_mis;
`endif
            end
            if (state == S_RD) begin
                if (is_load(op_p0)) rdata_p0 <= load_data;
                else                wdata_p0 <= merged;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed load/store sequences checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_lsu;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int IDXW      = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;

    logic [31:0] dev_mem [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] pc_seq = 32'h0000_0400;

    // Expectations for the transaction in flight, filled in before it is issued.
    int          m_lat, m_wek, m_rdk, m_idx;
    logic [31:0] m_rd, m_nword, m_pc;
    logic        m_err;

    bit          busy = 0;
    int          t0, first_k, we_cnt;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    lsu #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_pc    (mem_pc),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = dev_mem[mem_addr[IDXW+1:2]];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) dev_mem[i] = 32'hA500_0000 | i;
        forever begin
            @(posedge clk);
            if (mem_we) dev_mem[mem_addr[IDXW+1:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What one request must produce: response latency, cycle of the read and of the
    // write (-1 = none), load result, error flag and the memory word after the access.
    function automatic void model(input lsu_op_e op, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output int lat, output int wek, output int rdk,
                                  output logic [31:0] rd, output logic err,
                                  output logic [31:0] nword);
        logic [31:0] a;
        int          sh;
        bit          mis;
        a = addr; rd = '0; err = 1'b0; nword = word; wek = -1; rdk = 1; lat = 2;
        mis = ((op == OP_LW || op == OP_SW) && a[1:0] != 2'b00) ||
              ((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]);
`ifdef LSU_MISALIGN_CHECK_EN
        if (mis) begin
            err = 1'b1; lat = 1; rdk = -1;
            return;
        end
`else
        if (mis) a = (op == OP_LW || op == OP_SW) ? (a & ~32'd3) : (a & ~32'd1);
`endif
        case (op)
            OP_LW: rd = word;
            OP_LB, OP_LBU: begin
                sh = 8 * int'(a[1:0]);
                rd = (word >> sh) & 32'hFF;
                if (op == OP_LB && rd[7]) rd |= 32'hFFFF_FF00;
            end
            OP_LH, OP_LHU: begin
                sh = 16 * int'(a[1]);
                rd = (word >> sh) & 32'hFFFF;
                if (op == OP_LH && rd[15]) rd |= 32'hFFFF_0000;
            end
            OP_SW: begin
                rdk = -1; wek = 1; nword = wd;
            end
            OP_SB: begin
                sh = 8 * int'(a[1:0]);
                lat = 3; wek = 2;
                nword = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end
            OP_SH: begin
                sh = 16 * int'(a[1]);
                lat = 3; wek = 2;
                nword = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            default: ;
        endcase
    endfunction

    // Per-cycle comparison of all DUT outputs against the model.
    initial begin
        int k;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'hA500_0000 | i;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0;
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_mem_pc", mem_pc, 0);
            end else if (!busy) begin
                chk("idle_req_ready", req_ready, 1);
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_mem_we", mem_we, 0);
                if (req_valid) begin
                    busy = 1; t0 = cyc; first_k = -1; we_cnt = 0;
                end
            end else begin
                k = cyc - t0;
                chk("busy_req_ready", req_ready, 0);
                chk("mem_we", mem_we, k == m_wek);
                chk("mem_pc", mem_pc, m_pc);
                if (k == m_rdk || k == m_wek)
                    chk("mem_addr", mem_addr[IDXW+1:0], {m_idx[IDXW-1:0], 2'b00});
                if (k == m_wek) begin
                    chk("mem_wdata", mem_wdata, m_nword);
                    ref_mem[m_idx] = m_nword;
                end
                if (mem_we) we_cnt++;
                if (rsp_valid && first_k < 0) first_k = k;
                chk("rsp_valid", rsp_valid, k >= m_lat);
                if (k >= m_lat) begin
                    chk("rsp_rdata", rsp_rdata, m_rd);
                    chk("rsp_err", rsp_err, m_err);
                    if (rsp_ready) begin
                        busy = 0; last_rdata = rsp_rdata; last_err = rsp_err;
                    end
                end
            end
        end
    end

    task automatic start_req(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd);
        int idx;
        idx = int'((addr >> 2) % 32'(MEM_WORDS));
        model(op, addr, wd, ref_mem[idx], m_lat, m_wek, m_rdk, m_rd, m_err, m_nword);
        pc_seq += 4;
        m_idx = idx; m_pc = pc_seq;
        req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc_seq; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no response after %0d cycles, required within 40", n);
        end
        #1;
    endtask

    task automatic run(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd);
        start_req(op, addr, wd);
        wait_done();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(OP_SW, 32'h10, 32'h1234_5678);
        chk("sw_lat", first_k, 2);
        chk("sw_we_pulses", we_cnt, 1);
        chk("sw_word", dev_mem[4], 32'h1234_5678);

        run(OP_LW, 32'h10, 32'h0);
        chk("lw_rdata", last_rdata, 32'h1234_5678);
        chk("lw_lat", first_k, 2);

        run(OP_SB, 32'h11, 32'h0000_00AB);
        chk("sb_word", dev_mem[4], 32'h1234_AB78);
        chk("sb_lat", first_k, 3);
        chk("sb_we_pulses", we_cnt, 1);

        run(OP_SW, 32'h10, 32'h80FF_7F01);
        run(OP_LB, 32'h12, 32'h0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FFFF);
        run(OP_LBU, 32'h12, 32'h0);
        chk("lbu_rdata", last_rdata, 32'h0000_00FF);
        run(OP_LH, 32'h12, 32'h0);
        chk("lh_rdata", last_rdata, 32'hFFFF_80FF);

        run(OP_SH, 32'h12, 32'h1234_BEEF);
        chk("sh_word", dev_mem[4], 32'hBEEF_7F01);
        chk("sh_lat", first_k, 3);
        run(OP_LB, 32'h13, 32'h0);
        chk("lb3_rdata", last_rdata, 32'hFFFF_FFBE);
        run(OP_LHU, 32'h10, 32'h0);
        chk("lhu_rdata", last_rdata, 32'h0000_7F01);

        run(OP_SW, 32'h1014, 32'hCAFE_F00D);
        chk("wrap_word", dev_mem[5], 32'hCAFE_F00D);
        run(OP_LW, 32'h14, 32'h0);
        chk("wrap_rdata", last_rdata, 32'hCAFE_F00D);

        rsp_ready = 1'b0;
        start_req(OP_LW, 32'h10, 32'h0);
        repeat (m_lat - 1 + 5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done();
        chk("bp_rdata", last_rdata, 32'hBEEF_7F01);
        chk("bp_first", first_k, 2);

        run(OP_LW, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_err", last_err, 1);
        chk("mis_rdata", last_rdata, 32'h0);
        chk("mis_lat", first_k, 1);
`else
        chk("mis_err", last_err, 0);
        chk("mis_rdata", last_rdata, 32'hBEEF_7F01);
        chk("mis_lat", first_k, 2);
`endif

        start_req(OP_SB, 32'h11, 32'h0000_00CD);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_word", dev_mem[4], 32'hBEEF_7F01);

        run(OP_LW, 32'h10, 32'h0);
        chk("post_rst_lw", last_rdata, 32'hBEEF_7F01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the data memory; word index = addr[log2(MEM_WORDS)+1:2].
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low (asserted at 0).
REQ-004 SHALL have port req_valid, input, 1, pipeline memory request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted when req_valid & req_ready.
REQ-006 SHALL have port req_op, input, 3, one of LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data (right-aligned for SH/SB).
REQ-009 SHALL have port req_pc, input, 32, PC of the issuing instruction, carried to mem_pc.
REQ-010 SHALL have port rsp_valid, output, 1, response present; held until rsp_ready.
REQ-011 SHALL have port rsp_ready, input, 1, pipeline consumes response.
REQ-012 SHALL have port rsp_rdata, output, 32, extended load data (0 for stores).
REQ-013 SHALL have port rsp_err, output, 1, misaligned access flag.
REQ-014 SHALL have ports mem_we (output, 1), mem_addr (output, 32, word-aligned byte address), mem_wdata (output, 32), mem_pc (output, 32), and mem_rdata (input, 32, combinational read of mem_addr).

Function
REQ-015 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL, on accept, register op, addr, wdata, pc; loads and SH/SB go to RD, SW goes to WR.
REQ-017 SHALL, in RD, drive mem_addr = {addr[31:2],2'b00}, mem_we = 0, and sample mem_rdata at the clock edge.
REQ-018 SHALL, for loads leaving RD, select byte addr[1:0] / halfword addr[1], sign-extend for LB/LH, zero-extend for LBU/LHU, and go to RESP.
REQ-019 SHALL, for SH/SB leaving RD, merge the store lanes into the sampled word (other bytes unchanged) and go to WR.
REQ-020 SHALL, in WR, assert mem_we for exactly one cycle with merged/full data, then go to RESP.
REQ-021 SHALL, in RESP, hold rsp_valid = 1 and stable data until rsp_ready, then return to IDLE; no new accept in the same cycle.
REQ-022 SHALL meet latency (accept cycle = 0): LW rsp_valid at 2, SW at 2, SB/SH at 3.
REQ-023 SHALL decode mem_we combinationally from state so it is never asserted outside WR.
REQ-024 SHALL wrap addresses beyond MEM_WORDS by index truncation, not flag them.

Reset
REQ-025 SHALL, while reset = 0, force state IDLE, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_pc = 0, all registered fields 0.
REQ-026 SHALL abort any in-flight operation on reset assertion with no memory write issued afterwards; the request is dropped, not replayed.
REQ-027 SHALL accept its first request in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL, with LSU_MISALIGN_CHECK_EN defined, flag LW/SW with addr[1:0]!=0 and LH/LHU/SH with addr[0]!=0: go directly IDLE->RESP, rsp_err = 1, rsp_rdata = 0, no RD/WR.
REQ-029 SHALL, without LSU_MISALIGN_CHECK_EN, tie rsp_err to 0 and force the offending low address bits to 0 before use.

Structure
REQ-030 SHALL place the req_op encodings and the FSM state encoding in shared package lsu_pkg.
REQ-031 SHALL implement lane select/extend and store merge in one combinational sub-module lsu_lane.

Verification
REQ-032 SHALL cover SW 0x12345678 to 0x10, then LW 0x10 -> one mem_we pulse, mem_wdata 0x12345678; load rsp_rdata 0x12345678 at cycle 2.
REQ-033 SHALL cover word 0x10 = 0x12345678, SB 0xAB to 0x11 -> RD then WR, mem_wdata 0x1234AB78, rsp_valid at cycle 3.
REQ-034 SHALL cover word 0x10 = 0x80FF7F01, LB 0x12 / LBU 0x12 / LH 0x12 -> 0xFFFFFFFF / 0x000000FF / 0xFFFF80FF.
REQ-035 SHALL cover rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable, req_ready 0 throughout.
REQ-036 SHALL cover reset = 0 asserted during RD of an SB -> mem_we never pulses, word unchanged, req_ready 1 one cycle after release.
REQ-037 SHALL cover LW 0x13 -> with LSU_MISALIGN_CHECK_EN: rsp_err 1 at cycle 1, no mem access; without: reads 0x10, rsp_err 0.
